// File: rtl/gnn_aggr_sequencer.sv
// rtl/gnn_aggr_sequencer.sv - multi-layer issue/capture/rescale controller for the 4x4 aggregation datapath
// Feeds each layer's saturated, rescaled result back as the next layer's features.
module gnn_aggr_sequencer #(
    parameter int AGGR_IN_SIZE  = 5,
    parameter int AGGR_OUT_SIZE = 7,
    parameter int SHIFT         = 1,
    parameter int LAYER_W       = 3,
    parameter int WAIT_TIMEOUT  = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [LAYER_W-1:0]          num_layers,
    input  logic [16*AGGR_IN_SIZE-1:0]  x_in,
    output logic [16*AGGR_IN_SIZE-1:0]  aggr_x,
    output logic                        aggr_start,
    input  logic                        aggr_done,
    input  logic [16*AGGR_OUT_SIZE-1:0] aggr_y,
    output logic [16*AGGR_OUT_SIZE-1:0] result,
    output logic                        result_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err,
    output logic [LAYER_W-1:0]          layer_idx
);
    localparam int IW    = AGGR_IN_SIZE;
    localparam int OW    = AGGR_OUT_SIZE;
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic signed [OW-1:0] SAT_MAX = OW'(2 ** (IW - 1) - 1);
    localparam logic signed [OW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    logic [16*IW-1:0]      r_buf;
    logic [16*OW-1:0]      r_result;
    logic [LAYER_W-1:0]    r_num_layers;
    logic [LAYER_W-1:0]    r_layer_idx;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_aggr_start;
    logic                  r_result_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_timeout_err;
    logic [16*IW-1:0]      w_feedback;

    // Arithmetic shift floors negatives; clamp back into the signed input range.
    function automatic logic [IW-1:0] sat(input logic signed [OW-1:0] v);
        logic signed [OW-1:0] sh;
        sh = v >>> SHIFT;
        if (sh > SAT_MAX)
            sh = SAT_MAX;
        else if (sh < SAT_MIN)
            sh = SAT_MIN;
        return sh[IW-1:0];
    endfunction

    always_comb begin
        w_feedback = '0;
        for (int i = 0; i < 16; i++)
            w_feedback[i*IW +: IW] = sat(aggr_y[i*OW +: OW]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_buf          <= '0;
            r_result       <= '0;
            r_num_layers   <= '0;
            r_layer_idx    <= '0;
            r_wait_cnt     <= '0;
            r_aggr_start   <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_aggr_start <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && num_layers != '0) begin
                        r_buf          <= x_in;
                        r_num_layers   <= num_layers;
                        r_layer_idx    <= '0;
                        r_timeout_err  <= 1'b0;
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b1;
                        r_aggr_start   <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (aggr_done) begin
                        r_result <= aggr_y;
                        if (r_layer_idx == r_num_layers - 1'b1) begin
                            r_done         <= 1'b1;
                            r_result_valid <= 1'b1;
                            r_busy         <= 1'b0;
                            r_state        <= S_DONE;
                        end else begin
                            r_buf        <= w_feedback;
                            r_layer_idx  <= r_layer_idx + 1'b1;
                            r_aggr_start <= 1'b1;
                            r_state      <= S_ISSUE;
                        end
                    end else if (r_wait_cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign aggr_x       = r_buf;
    assign aggr_start   = r_aggr_start;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout_err  = r_timeout_err;
    assign layer_idx    = r_layer_idx;
endmodule

// File: tb/tb_gnn_aggr_sequencer.sv
// tb/tb_gnn_aggr_sequencer.sv - table-driven bench for gnn_aggr_sequencer with a ring aggregation model
module tb_gnn_aggr_sequencer;
    localparam int IW = 5;
    localparam int OW = 7;
    localparam int LW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LW-1:0]     num_layers;
    logic [16*IW-1:0]  x_in;
    logic [16*IW-1:0]  aggr_x;
    logic              aggr_start;
    logic              aggr_done;
    logic [16*OW-1:0]  aggr_y;
    logic [16*OW-1:0]  result;
    logic              result_valid;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [LW-1:0]     layer_idx;

    logic              model_en = 1'b1;
    logic              model_done = 1'b0;
    logic [16*OW-1:0]  model_y = '0;
    logic              stray = 1'b0;
    logic [16*OW-1:0]  stray_y = '0;

    int n_pass  = 0;
    int n_total = 0;
    int li_trace [0:63];

    always #5 clk = ~clk;

    gnn_aggr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_layers(num_layers), .x_in(x_in),
        .aggr_x(aggr_x), .aggr_start(aggr_start), .aggr_done(aggr_done), .aggr_y(aggr_y),
        .result(result), .result_valid(result_valid), .busy(busy), .done(done),
        .timeout_err(timeout_err), .layer_idx(layer_idx)
    );

    // Aggregation model: each node sums itself with its two ring neighbours, 1-cycle latency, no reset.
    function automatic logic [16*OW-1:0] aggr_model(input logic [16*IW-1:0] x);
        logic [16*OW-1:0] y;
        int s;
        y = '0;
        for (int n = 0; n < 4; n++)
            for (int f = 0; f < 4; f++) begin
                s = $signed(x[(((n + 3) % 4) * 4 + f) * IW +: IW])
                  + $signed(x[(n * 4 + f) * IW +: IW])
                  + $signed(x[(((n + 1) % 4) * 4 + f) * IW +: IW]);
                y[(n * 4 + f) * OW +: OW] = s[OW-1:0];
            end
        return y;
    endfunction

    always @(posedge clk) begin
        if (model_en && aggr_start) begin
            model_y    <= aggr_model(aggr_x);
            model_done <= 1'b1;
        end else begin
            model_done <= 1'b0;
        end
    end

    assign aggr_done = model_done | stray;
    assign aggr_y    = stray ? stray_y : model_y;

    function automatic logic [16*IW-1:0] rep_x(input logic [IW-1:0] v);
        logic [16*IW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*IW +: IW] = v;
        return r;
    endfunction

    function automatic logic [16*OW-1:0] rep_y(input logic [OW-1:0] v);
        logic [16*OW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*OW +: OW] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Start sampled at cycle 0; every negedge afterwards observes cycle c.
    task automatic run(input logic [16*IW-1:0] x, input int nl, input int mid_c,
                       output int done_cyc, output int as_count, output int as_first);
        @(negedge clk);
        x_in = x; num_layers = LW'(nl); start = 1'b1;
        @(negedge clk);
        start = 1'b0; num_layers = '0;
        done_cyc = -1; as_count = 0; as_first = -1;
        for (int c = 1; c <= 60; c++) begin
            li_trace[c] = int'(layer_idx);
            if (aggr_start) begin
                as_count++;
                if (as_first < 0) as_first = c;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            if (c == mid_c) begin
                start = 1'b1; num_layers = LW'(1);
            end else begin
                start = 1'b0; num_layers = '0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic signed [IW-1:0] x_val;
        int                   layers;
        int                   mid_c;
        logic signed [OW-1:0] exp_y;
        int                   exp_cyc;
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        int dc, asc, asf, nd, err_c;
        logic [16*OW-1:0] held;

        vecs[0] = '{x_val:  5'sd1,  layers: 1, mid_c: -1, exp_y:  7'sd3,  exp_cyc: 3};
        vecs[1] = '{x_val:  5'sd5,  layers: 2, mid_c: -1, exp_y:  7'sd21, exp_cyc: 5};
        vecs[2] = '{x_val:  5'sd15, layers: 2, mid_c: -1, exp_y:  7'sd45, exp_cyc: 5};
        vecs[3] = '{x_val: -5'sd16, layers: 2, mid_c: -1, exp_y: -7'sd48, exp_cyc: 5};
        vecs[4] = '{x_val: -5'sd1,  layers: 2, mid_c: -1, exp_y: -7'sd6,  exp_cyc: 5};
        vecs[5] = '{x_val:  5'sd2,  layers: 3, mid_c: -1, exp_y:  7'sd12, exp_cyc: 7};
        vecs[6] = '{x_val:  5'sd1,  layers: 3, mid_c:  3, exp_y:  7'sd3,  exp_cyc: 7};

        rst_n = 1'b0; start = 1'b0; num_layers = '0; x_in = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_layer_idx", layer_idx, 0);
        check("rst_result", result, 0);
        check("rst_aggr_x", aggr_x, 0);
        check("rst_aggr_start", aggr_start, 0);
        rst_n = 1'b1;
        @(negedge clk);

        stray_y = rep_y(7'sd9); stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        check("stray_after_reset_result", result, 0);
        check("stray_after_reset_busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            run(rep_x(vecs[i].x_val), vecs[i].layers, vecs[i].mid_c, dc, asc, asf);
            check($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_cyc);
            check($sformatf("v%0d_result", i), result, rep_y(vecs[i].exp_y));
            check($sformatf("v%0d_result_valid", i), result_valid, 1);
            check($sformatf("v%0d_busy", i), busy, 0);
            check($sformatf("v%0d_issue_count", i), asc, vecs[i].layers);
            check($sformatf("v%0d_first_issue", i), asf, 1);
            nd = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (done) nd++;
            end
            check($sformatf("v%0d_extra_done", i), nd, 0);
            check($sformatf("v%0d_valid_hold", i), result_valid, 1);
            if (i == 1) begin
                check("v1_layer_idx_c2", li_trace[2], 0);
                check("v1_layer_idx_c4", li_trace[4], 1);
            end
        end

        held = result;
        @(negedge clk);
        x_in = rep_x(5'sd7); num_layers = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int k = 0; k < 4; k++) begin
            if (aggr_start || busy) nd++;
            @(negedge clk);
        end
        check("nl0_no_activity", nd, 0);
        check("nl0_result", result, held);
        check("nl0_result_valid", result_valid, 1);

        stray_y = rep_y(-7'sd20); stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        check("stray_idle_result", result, held);
        check("stray_idle_valid", result_valid, 1);

        model_en = 1'b0;
        @(negedge clk);
        x_in = rep_x(5'sd1); num_layers = LW'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        err_c = -1; nd = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) nd++;
            if (timeout_err && err_c < 0) err_c = c;
            @(negedge clk);
        end
        check("to_err_cycle", err_c, 17);
        check("to_no_done", nd, 0);
        check("to_busy", busy, 0);
        check("to_result_valid", result_valid, 0);
        check("to_sticky", timeout_err, 1);
        model_en = 1'b1;
        run(rep_x(5'sd1), 1, -1, dc, asc, asf);
        check("to_recover_done_cycle", dc, 3);
        check("to_recover_err_cleared", timeout_err, 0);
        check("to_recover_result", result, rep_y(7'sd3));

        @(negedge clk);
        x_in = rep_x(5'sd1); num_layers = LW'(3); start = 1'b1;
        @(negedge clk);
        start = 1'b0; num_layers = '0;
        repeat (3) @(negedge clk);
        check("mid_layer_idx", layer_idx, 1);
        check("mid_busy", busy, 1);
        check("mid_result_l1", result, rep_y(7'sd3));
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_layer_idx", layer_idx, 0);
        check("arst_result", result, 0);
        check("arst_aggr_x", aggr_x, 0);
        check("arst_result_valid", result_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(rep_x(5'sd5), 2, -1, dc, asc, asf);
        check("post_rst_done_cycle", dc, 5);
        check("post_rst_result", result, rep_y(7'sd21));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
